// File: rtl/iterative_carryless_multiplier_if.sv
// Request/response bundle for the iterative carry-less multiplier.
// The master issues operands and mode; the slave returns ready, result and a valid pulse.
interface iterative_carryless_multiplier_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] operand_A_i;
   logic [DATA_WIDTH-1:0] operand_B_i;
   logic [1:0]            mode_i;
   logic                  data_valid_i;
   logic                  ready_o;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  data_valid_o;

   modport master (
      output operand_A_i,
      output operand_B_i,
      output mode_i,
      output data_valid_i,
      input  ready_o,
      input  result_o,
      input  data_valid_o
   );

   modport slave (
      input  operand_A_i,
      input  operand_B_i,
      input  mode_i,
      input  data_valid_i,
      output ready_o,
      output result_o,
      output data_valid_o
   );
endinterface

// File: rtl/iterative_carryless_multiplier.sv
// Sequential GF(2) polynomial multiplier (clmul / clmulh / clmulr).
// Consumes BITS_PER_CYCLE multiplier bits per cycle; fixed latency of W/K + 2 cycles.
module iterative_carryless_multiplier #(
   parameter int DATA_WIDTH     = 32,
   parameter int BITS_PER_CYCLE = 4
) (
   input logic                            clk_i,
   input logic                            rst_i,
   iterative_carryless_multiplier_if.slave bus
);
   localparam int W     = DATA_WIDTH;
   localparam int K     = BITS_PER_CYCLE;
   localparam int N     = W / K;
   localparam int CNT_W = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   generate
      if (DATA_WIDTH < 2) begin : g_bad_width
         $error("DATA_WIDTH must be at least 2");
      end
      if (DATA_WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_k
         $error("DATA_WIDTH must be a multiple of BITS_PER_CYCLE");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_t;

   state_t             state;
   logic [2*W-1:0]     acc;
   logic [2*W-1:0]     a_sh;
   logic [2*W-1:0]     partial;
   logic [W-1:0]       b_reg;
   logic [W-1:0]       sel;
   logic [1:0]         mode_r;
   logic [CNT_W-1:0]   cnt;

   // XOR of this cycle's K shifted multiplicand copies selected by the low multiplier bits.
   // a_sh already carries the cnt*K offset, so only the per-bit shift j remains here.
   always_comb begin
      partial = '0;
      for (int unsigned j = 0; j < K; j++) begin
         if (b_reg[j]) partial = partial ^ (a_sh << j);
      end
   end

   // Mode-selected window of the full product; reserved mode falls back to low half.
   always_comb begin
      case (mode_r)
         2'b01:   sel = acc[2*W-1:W];
         2'b10:   sel = acc[2*W-2:W-1];
         default: sel = acc[W-1:0];
      endcase
   end

   // Control FSM with registered ready/valid/result outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state            <= IDLE;
         bus.ready_o      <= 1'b1;
         bus.data_valid_o <= 1'b0;
         bus.result_o     <= '0;
         acc              <= '0;
         a_sh             <= '0;
         b_reg            <= '0;
         mode_r           <= '0;
         cnt              <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.data_valid_o <= 1'b0;
               if (bus.data_valid_i) begin
                  a_sh        <= {{W{1'b0}}, bus.operand_A_i};
                  b_reg       <= bus.operand_B_i;
                  mode_r      <= bus.mode_i;
                  acc         <= '0;
                  cnt         <= '0;
                  bus.ready_o <= 1'b0;
                  state       <= COMPUTE;
               end
            end
            COMPUTE: begin
               acc   <= acc ^ partial;
               a_sh  <= a_sh << K;
               b_reg <= b_reg >> K;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_CNT) state <= DONE;
            end
            DONE: begin
               bus.result_o     <= sel;
               bus.data_valid_o <= 1'b1;
               bus.ready_o      <= 1'b1;
               state            <= IDLE;
            end
            default: begin
               bus.ready_o      <= 1'b1;
               bus.data_valid_o <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_iterative_carryless_multiplier.sv
// Directed and random checks for the iterative carry-less multiplier (W=32, K=4).
module tb_iterative_carryless_multiplier;
   localparam int W = 32;
   localparam int K = 4;
   localparam int N = W / K;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   int   acc_edge = 0;

   iterative_carryless_multiplier_if #(.DATA_WIDTH(W)) bus ();

   iterative_carryless_multiplier #(
      .DATA_WIDTH    (W),
      .BITS_PER_CYCLE(K)
   ) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Free-running edge counter used for latency measurement.
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  mode;
      logic [31:0] expect_res;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_clmul(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] m);
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
      case (m)
         2'b01:   return p[63:32];
         2'b10:   return p[62:31];
         default: return p[31:0];
      endcase
   endfunction

   task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.ready_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) check("ready_timeout", 32'(bus.ready_o), 32'd1);
      bus.operand_A_i  = a;
      bus.operand_B_i  = b;
      bus.mode_i       = m;
      bus.data_valid_i = 1'b1;
      @(posedge clk);
      #1;
      acc_edge = edge_cnt;
      bus.data_valid_i = 1'b0;
      check("accept", 32'(bus.ready_o), 32'd0);
   endtask

   task automatic wait_done(output logic [31:0] res, output int lat);
      int w;
      w = 0;
      while (!bus.data_valid_o && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 100) check("done_timeout", 32'(bus.data_valid_o), 32'd1);
      check("ready_in_pulse", 32'(bus.ready_o), 32'd1);
      res = bus.result_o;
      lat = edge_cnt - acc_edge;
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  m;
      int          lat;
      int          prev_edge;
      int          seen;

      vecs[0]  = '{32'h00000003, 32'h00000005, 2'b00, 32'h0000000F};
      vecs[1]  = '{32'h80000000, 32'h80000000, 2'b00, 32'h00000000};
      vecs[2]  = '{32'h80000000, 32'h80000000, 2'b01, 32'h40000000};
      vecs[3]  = '{32'h80000000, 32'h80000000, 2'b10, 32'h80000000};
      vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h55555555};
      vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h55555555};
      vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hAAAAAAAA};
      vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h55555555};
      vecs[8]  = '{32'h00000001, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF};
      vecs[9]  = '{32'h00010000, 32'h00010000, 2'b01, 32'h00000001};
      vecs[10] = '{32'h00010000, 32'h00010000, 2'b10, 32'h00000002};
      vecs[11] = '{32'h00000000, 32'hFFFFFFFF, 2'b10, 32'h00000000};
      vecs[12] = '{32'hFFFFFFFF, 32'h00000002, 2'b00, 32'hFFFFFFFE};
      vecs[13] = '{32'hFFFFFFFF, 32'h00000002, 2'b10, 32'h00000003};

      bus.operand_A_i  = '0;
      bus.operand_B_i  = '0;
      bus.mode_i       = '0;
      bus.data_valid_i = 1'b1;  // must be overridden by reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.ready_o), 32'd1);
      check("rst_valid", 32'(bus.data_valid_o), 32'd0);
      check("rst_result", bus.result_o, 32'h0);
      @(negedge clk);
      bus.data_valid_i = 1'b0;
      rst = 1'b0;

      // First op: latency and pulse width.
      start_req(32'h3, 32'h5, 2'b00);
      wait_done(res, lat);
      check("first_result", res, 32'h0000000F);
      check("first_latency", 32'(lat), 32'(N + 1));
      @(posedge clk);
      #1;
      check("pulse_width", 32'(bus.data_valid_o), 32'd0);

      // Table vectors issued back to back; throughput is one result per N+2 cycles.
      prev_edge = 0;
      for (int i = 0; i < 14; i++) begin
         start_req(vecs[i].a, vecs[i].b, vecs[i].mode);
         if (i > 0) check($sformatf("throughput_%0d", i), 32'(acc_edge - prev_edge), 32'(N + 2));
         prev_edge = acc_edge;
         wait_done(res, lat);
         check($sformatf("vec_%0d", i), res, vecs[i].expect_res);
         check($sformatf("vec_lat_%0d", i), 32'(lat), 32'(N + 1));
      end

      // Request while busy is ignored and operand changes have no effect.
      start_req(32'h3, 32'h5, 2'b00);
      @(negedge clk);
      @(negedge clk);
      bus.operand_A_i  = 32'hFFFFFFFF;
      bus.operand_B_i  = 32'hFFFFFFFF;
      bus.mode_i       = 2'b01;
      bus.data_valid_i = 1'b1;
      check("busy_ready", 32'(bus.ready_o), 32'd0);
      @(posedge clk);
      #1;
      bus.data_valid_i = 1'b0;
      wait_done(res, lat);
      check("busy_result", res, 32'h0000000F);
      check("busy_latency", 32'(lat), 32'(N + 1));
      start_req(32'h7, 32'h3, 2'b00);
      wait_done(res, lat);
      check("after_busy", res, 32'h00000009);

      // Reset during the third COMPUTE cycle abandons the operation.
      start_req(32'h3, 32'h5, 2'b00);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_ready", 32'(bus.ready_o), 32'd1);
      check("midrst_result", bus.result_o, 32'h0);
      check("midrst_valid", 32'(bus.data_valid_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (bus.data_valid_o) seen = 1;
      end
      check("midrst_no_pulse", 32'(seen), 32'd0);
      start_req(32'h80000000, 32'h80000000, 2'b01);
      wait_done(res, lat);
      check("post_rst", res, 32'h40000000);
      check("post_rst_lat", 32'(lat), 32'(N + 1));

      // Random regression against the bitwise reference model.
      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         b = $urandom;
         m = 2'($urandom_range(0, 3));
         start_req(a, b, m);
         wait_done(res, lat);
         check($sformatf("rand_%0d", i), res, ref_clmul(a, b, m));
         check($sformatf("rand_lat_%0d", i), 32'(lat), 32'(N + 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
